bypass_scoreboard_unit: RTL

//  Parametrised ID-stage operand bypass and interlock unit. Forwards from NSTG downstream stages to NRD read ports.

---
 rtl/bypass_scoreboard_unit_if.sv | 42 ++++
 rtl/bypass_scoreboard_unit.sv | 93 +++++++++
 2 files changed

// File: rtl/bypass_scoreboard_unit_if.sv
// Operand-read, stage-forwarding and long-latency scoreboard signals of the ID-stage bypass unit.
// master = pipeline side driving requests, slave = bypass_scoreboard_unit.
interface bypass_scoreboard_unit_if #(
    parameter int NRD   = 2,
    parameter int NSTG  = 3,
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int NPEND = 4
);
    localparam int PW = $clog2(NPEND + 1);

    logic [NRD*AW-1:0]  rd_addr;
    logic [NRD*DW-1:0]  rd_data_rf;
    logic [NSTG-1:0]    stg_valid;
    logic [NSTG-1:0]    stg_we;
    logic [NSTG*AW-1:0] stg_waddr;
    logic [NSTG*DW-1:0] stg_wdata;
    logic [NSTG-1:0]    stg_rdy;
    logic               issue_valid;
    logic               issue_long;
    logic [AW-1:0]      issue_waddr;
    logic               lret_valid;
    logic [AW-1:0]      lret_waddr;
    logic               flush;
    logic [NRD*DW-1:0]  rd_data_byp;
    logic               stall;
    logic [PW-1:0]      pend_cnt;
    logic               pend_full;
    logic               sb_err;

    modport master (
        output rd_addr, rd_data_rf, stg_valid, stg_we, stg_waddr, stg_wdata, stg_rdy,
        output issue_valid, issue_long, issue_waddr, lret_valid, lret_waddr, flush,
        input  rd_data_byp, stall, pend_cnt, pend_full, sb_err
    );

    modport slave (
        input  rd_addr, rd_data_rf, stg_valid, stg_we, stg_waddr, stg_wdata, stg_rdy,
        input  issue_valid, issue_long, issue_waddr, lret_valid, lret_waddr, flush,
        output rd_data_byp, stall, pend_cnt, pend_full, sb_err
    );
endinterface

// File: rtl/bypass_scoreboard_unit.sv
// ID-stage operand bypass/interlock with a busy-bit scoreboard for long-latency writers.
// Define BYPASS_EN to forward stage results; otherwise any stage hit interlocks and the regfile data is used.
module bypass_scoreboard_unit #(
    parameter int NRD   = 2,
    parameter int NSTG  = 3,
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int NPEND = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    bypass_scoreboard_unit_if.slave  bus
);
    localparam int PW = $clog2(NPEND + 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(NPEND);

    logic [2**AW-1:0] r_busy;
    logic [PW-1:0]    r_pend_cnt;
    logic             r_sb_err;

    logic [AW-1:0]    w_addr [NRD];
    logic [NSTG-1:0]  w_hit  [NRD];
    logic [NRD-1:0]   w_port_stall;
    logic [NRD*DW-1:0] w_byp;
    logic             w_pend_full;
    logic             w_issue_stall;
    logic             w_stall;
    logic             w_accept;
    logic             w_lret_clear;

    for (genvar p = 0; p < NRD; p++) begin : g_port
        assign w_addr[p] = bus.rd_addr[p*AW +: AW];
        for (genvar s = 0; s < NSTG; s++) begin : g_stg
            assign w_hit[p][s] = bus.stg_valid[s] & bus.stg_we[s] & (w_addr[p] != '0)
                               & (w_addr[p] == bus.stg_waddr[s*AW +: AW]);
        end
    end

    // Youngest hitting stage owns the operand; an older ready copy is stale and must not hide it.
    always_comb begin
        w_byp        = bus.rd_data_rf;
        w_port_stall = '0;
        for (int p = 0; p < NRD; p++) begin
            logic found;
            found = 1'b0;
            for (int s = 0; s < NSTG; s++) begin
                if (w_hit[p][s] && !found) begin
                    found = 1'b1;
`ifdef BYPASS_EN
                    w_byp[p*DW +: DW] = bus.stg_wdata[s*DW +: DW];
                    if (!bus.stg_rdy[s]) w_port_stall[p] = 1'b1;
`else
                    w_port_stall[p] = 1'b1;
`endif
                end
            end
            if (r_busy[w_addr[p]]) w_port_stall[p] = 1'b1;
        end
    end

`ifndef BYPASS_EN
    logic w_unused_byp;
    assign w_unused_byp = ^{bus.stg_wdata, bus.stg_rdy};
`endif

    assign w_pend_full   = (r_pend_cnt == PEND_MAX);
    assign w_issue_stall = bus.issue_valid & bus.issue_long & (w_pend_full | r_busy[bus.issue_waddr]);
    assign w_stall       = !bus.flush & bus.issue_valid & ((|w_port_stall) | w_issue_stall);
    assign w_accept      = bus.issue_valid & bus.issue_long & !w_stall & !bus.flush
                         & (bus.issue_waddr != '0);
    assign w_lret_clear  = bus.lret_valid & r_busy[bus.lret_waddr];

    // Busy bits and the pending count survive flush: in-flight long ops still retire through lret.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_busy     <= '0;
            r_pend_cnt <= '0;
            r_sb_err   <= 1'b0;
        end else begin
            if (w_lret_clear) r_busy[bus.lret_waddr] <= 1'b0;
            if (w_accept)     r_busy[bus.issue_waddr] <= 1'b1;
            if (bus.lret_valid && !r_busy[bus.lret_waddr]) r_sb_err <= 1'b1;
            if (w_accept && !w_lret_clear)      r_pend_cnt <= r_pend_cnt + 1'b1;
            else if (!w_accept && w_lret_clear) r_pend_cnt <= r_pend_cnt - 1'b1;
        end
    end

    assign bus.rd_data_byp = w_byp;
    assign bus.stall       = w_stall;
    assign bus.pend_cnt    = r_pend_cnt;
    assign bus.pend_full   = w_pend_full;
    assign bus.sb_err      = r_sb_err;
endmodule
